// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter
//   Round-robin, packet-locking (wormhole) arbiter for one router output.
//   A requesting, non-empty input FIFO is granted in IDLE, then its flits are
//   popped one at a time (POP) and written downstream the following cycle
//   (FWD) until the tail flit (bit NUM_BITS-1 set) has been forwarded.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous reset, ACTIVE HIGH despite the name
//   req        per-input request (head flit routed to this output)
//   in_empty   per-input FIFO empty flag
//   in_data    flattened registered FIFO outputs, slice i = [i*NUM_BITS +: NUM_BITS]
//   rd_en      per-input pop strobe (at most one bit high)
//   out_full   downstream FIFO full flag
//   out_flit   flit presented to the downstream FIFO
//   out_valid  downstream write enable
//   grant      one-hot registered owner, zero when idle
//   busy       a packet currently owns the output
module noc_output_arbiter #(
  parameter int NUM_IN   = 4,
  parameter int NUM_BITS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN-1:0]            req,
  input  logic [NUM_IN-1:0]            in_empty,
  input  logic [NUM_IN*NUM_BITS-1:0]   in_data,
  output logic [NUM_IN-1:0]            rd_en,
  input  logic                         out_full,
  output logic [NUM_BITS-1:0]          out_flit,
  output logic                         out_valid,
  output logic [NUM_IN-1:0]            grant,
  output logic                         busy
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_FWD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_IN-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_IN-1:0]   elig;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    win_next;
  int                  cand;
  logic [PTR_W-1:0]    g_idx;
  logic [NUM_BITS-1:0] sel_flit;
  logic [NUM_IN-1:0]   rd_en_raw;
  logic                out_valid_raw;

  // Unflatten the FIFO output bus.
  logic [NUM_BITS-1:0] slice [NUM_IN];
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_slice
      assign slice[gi] = in_data[gi*NUM_BITS +: NUM_BITS];
    end
  endgenerate

  assign elig = req & ~in_empty;

  // First eligible port at or above rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_IN) cand = cand - NUM_IN;
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  assign win_next = (win_idx == PTR_W'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;

  // Binary index of the current owner (grant_q is one-hot or zero).
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_q[i]) g_idx = PTR_W'(i);
    end
  end

  assign sel_flit = (|grant_q) ? slice[g_idx] : '0;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    rd_en_raw     = '0;
    out_valid_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d  = NUM_IN'(1) << win_idx;
          rr_ptr_d = win_next;
          state_d  = S_POP;
        end
      end
      S_POP: begin
        // Downstream fullness is only sampled here, one cycle after the
        // previous write, so its count already reflects that write.
        if (!in_empty[g_idx] && !out_full) begin
          rd_en_raw = grant_q;
          state_d   = S_FWD;
        end
      end
      S_FWD: begin
        out_valid_raw = 1'b1;
        if (sel_flit[NUM_BITS-1]) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else begin
          state_d = S_POP;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // No pop or downstream write may escape during a reset cycle.
  assign rd_en     = rst_n ? '0 : rd_en_raw;
  assign out_valid = rst_n ? 1'b0 : out_valid_raw;
  assign out_flit  = rst_n ? '0 : sel_flit;
  assign grant     = grant_q;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

Round-robin, packet-locking (wormhole) output-port arbiter for one router output. Shares the output link between `NUM_IN` input-port FIFOs: selects one requesting FIFO, pops its flits one at a time through the FIFO's `rd_en`, and forwards each flit to the downstream FIFO's write side until the tail flit has passed. It sits between the input-buffer FIFOs and the downstream/output FIFO, with route computation supplying `req`.

## Interface
- `NUM_IN`, 4: number of input FIFOs arbitrated. Must be ≥2.
- `NUM_BITS`, 8: flit width. Bit `NUM_BITS-1` is the tail flag.
- `clk` input, 1: sole clock, rising edge.
- `rst_n` input, 1: reset, synchronous and active-high. Sampled at `clk` rise; a value of 1 resets the block.
- `req` input, `NUM_IN`: bit i is 1 when the head flit of FIFO i is routed to this output.
- `in_empty` input, `NUM_IN`: empty flags of the input FIFOs.
- `in_data` input, `NUM_IN*NUM_BITS`: registered `fifo_out` of each FIFO, flattened. Slice i is `[i*NUM_BITS +: NUM_BITS]`.
- `rd_en` output, `NUM_IN`: pop strobe to each input FIFO. At most one bit is high.
- `out_full` input, 1: full flag of the downstream FIFO.
- `out_flit` output, `NUM_BITS`: flit to the downstream FIFO (`fifo_in`).
- `out_valid` output, 1: downstream write enable (`wr_en`).
- `grant` output, `NUM_IN`: one-hot registered owner of the output. All zeros when idle.
- `busy` output, 1: high while a packet is owned (state ≠ IDLE).

## Operation
- **State register**: IDLE, POP, FWD. Also registered `grant` (one-hot) and `rr_ptr` (`clog2(NUM_IN)` bits).
- **Eligibility**: `elig = req & ~in_empty`.
- **IDLE**:
  - If `elig` is nonzero, the winner is the first set bit searching upward from `rr_ptr`, wrapping modulo `NUM_IN`.
  - Registers: `grant` is set to the one-hot of the winner, `rr_ptr` to (winner+1) mod `NUM_IN`, and the state goes to POP.
  - Otherwise the block stays in IDLE.
- **POP** (g = granted index):
  - `rd_en[g] = !in_empty[g] && !out_full`, combinational.
  - If the pop is issued, go to FWD. Otherwise stay in POP with no pop.
  - A mid-packet empty FIFO or a full downstream FIFO stalls the block indefinitely. Ownership is kept throughout.
- **FWD**:
  - `out_valid = 1`, combinational.
  - `out_flit = in_data` slice g, which is the flit popped in the previous cycle.
  - If `out_flit[NUM_BITS-1]` is 1 (tail), go to IDLE and clear `grant` to 0. Otherwise go to POP.
- **Outputs outside FWD**: `out_flit = in_data` slice of the granted index, or 0 when `grant` is 0. `out_valid = 0`.
- **Packet lock**: `req` and `elig` of other ports are ignored from grant until the tail flit is forwarded. Re-arbitration happens only in IDLE.
- **Single-flit packet**: a flit whose tail bit is set on its first pop. It takes one POP and one FWD cycle.
- **`rd_en`/`out_valid` under reset**: both are forced to 0 combinationally whenever `rst_n` = 1. No pop or write occurs in a reset cycle.
- **Reset, including mid-packet**: state = IDLE, `grant` = 0, `rr_ptr` = 0, `busy` = 0, `rd_en` = 0, `out_valid` = 0, `out_flit` = 0.
  - Partially forwarded packets are abandoned. The input FIFOs are reset by the same `rst_n`.

## Timing
- Grant latency: `req` and `!in_empty` sampled high in IDLE at edge t give `grant`/`busy` high from cycle t+1. The first `rd_en` can be high in cycle t+1.
- Pop latency: `rd_en` high in cycle n makes the FIFO's registered output valid in cycle n+1. The same flit appears on `out_flit` with `out_valid` in cycle n+1.
- Throughput: one flit per 2 cycles. The tail is known before any further pop, so no flit of a following packet is ever popped early.
- Backpressure: `out_full` is checked only in POP, the cycle after the previous write. The downstream counter therefore already includes that write, and no write is ever made to a full FIFO.
- Packet turnaround: the tail FWD cycle is followed by one IDLE cycle before the next grant becomes effective.

## Test plan
- **Reset**: hold `rst_n`=1 for 2 cycles with all `req` high and FIFOs non-empty → `grant`=0, `busy`=0, `rd_en`=0, `out_valid`=0, `out_flit`=0, and no FIFO pointer moves.
- **Single 3-flit packet** (NUM_IN=4, NUM_BITS=8): FIFO 2 holds 0x11, 0x22, 0x93 with `req[2]`=1 → `grant`=4'b0100 one cycle later. `rd_en[2]` pulses on alternate cycles. `out_valid` carries 0x11, 0x22, 0x93 in that order, then `busy`=0 and `grant`=0.
- **Round-robin fairness**: all four ports request single-flit packets 0x80|i → service order 0, 1, 2, 3. Then ports 0 and 2 request again → order 0, 2. With `rr_ptr` = 3 and ports 0 and 3 requesting → 3 first.
- **Wormhole lock**: port 1 is mid-packet and port 0 raises `req` → no `rd_en[0]` until port 1's tail flit (bit 7 = 1) is forwarded. Port 0 is granted one cycle after that.
- **Stalls**:
  - `out_full`=1 for 5 cycles mid-packet → `rd_en`=0 and `out_valid`=0 throughout. Delivery resumes in order with no loss or duplication.
  - Input FIFO empties mid-packet for 3 cycles → same result, and `grant` is held.
- **Reset mid-packet**: assert `rst_n` between the 2nd and 3rd flit → IDLE, `grant`=0, `rr_ptr`=0 the next cycle, with no `out_valid` in the reset cycle.
